// File: rtl/wb_port_scheduler_pkg.sv
// Shared CPU constants and the writeback result entry type.
package wb_port_scheduler_pkg;

  localparam int unsigned WbFifoDepth = 2;
  localparam int unsigned RegAddrW    = 5;
  localparam int unsigned DataW       = 32;

  // One queued multi-cycle result; valid drops when a newer pipeline write supersedes it.
  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] da;
    logic [DataW-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order result queue with cancel-by-address. Cancelled entries keep their slot until popped.
module wb_result_fifo
  import wb_port_scheduler_pkg::*;
#(
  parameter int unsigned Depth = WbFifoDepth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [RegAddrW-1:0] push_da_i,
  input  logic [DataW-1:0]    push_data_i,
  input  logic                pop_i,
  input  logic                cancel_i,
  input  logic [RegAddrW-1:0] cancel_da_i,
  output logic                full_o,
  output logic                head_present_o,
  output logic                head_valid_o,
  output logic [RegAddrW-1:0] head_da_o,
  output logic [DataW-1:0]    head_data_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  wb_entry_t           entries_q [Depth];
  wb_entry_t           entries_d [Depth];
  logic [CntW-1:0]     count_q, count_d;

  assign full_o         = (count_q == CntW'(Depth));
  assign head_present_o = (count_q != '0);
  assign head_valid_o   = entries_q[0].valid;
  assign head_da_o      = entries_q[0].da;
  assign head_data_o    = entries_q[0].data;

  // Next state: cancel stored entries first, then shift out the head, then append the push.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      entries_d[i] = entries_q[i];
    end
    count_d = count_q;

    // Only entries present before this edge are cancelled; an arriving push survives.
    for (int unsigned i = 0; i < Depth; i++) begin
      if (cancel_i && (CntW'(i) < count_q) && (entries_q[i].da == cancel_da_i)) begin
        entries_d[i].valid = 1'b0;
      end
    end

    if (pop_i && (count_q != '0)) begin
      for (int unsigned i = 0; i + 1 < Depth; i++) begin
        entries_d[i] = entries_d[i + 1];
      end
      entries_d[Depth - 1] = '0;
      count_d = count_q - CntW'(1);
    end

    if (push_i && (count_d != CntW'(Depth))) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (count_d == CntW'(i)) begin
          entries_d[i] = '{valid: 1'b1, da: push_da_i, data: push_data_i};
        end
      end
      count_d = count_d + CntW'(1);
    end
  end

  // Queue storage with synchronous reset to empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

endmodule

// File: rtl/wb_port_scheduler.sv
// Single register-file write port shared by the pipeline and a multi-cycle unit.
// The pipeline has priority; queued results get through when the pipeline is idle
// or when the starve counter forces a one-cycle pipeline stall.
module wb_port_scheduler
  import wb_port_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4  // legal 1..7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_RW,
  input  logic [RegAddrW-1:0] p_DA,
  input  logic [DataW-1:0]    p_data,
  output logic                p_stall,
  input  logic                m_valid,
  input  logic [RegAddrW-1:0] m_DA,
  input  logic [DataW-1:0]    m_data,
  output logic                m_ready,
  output logic                RW,
  output logic [RegAddrW-1:0] DA,
  output logic [DataW-1:0]    BusD
);

  localparam int unsigned StarveW = 3;

  logic                fifo_full;
  logic                head_present;
  logic                head_valid;
  logic [RegAddrW-1:0] head_da;
  logic [DataW-1:0]    head_data;

  logic                push;
  logic                grant_p;
  logic                pop_head;
  logic                write_head;

  logic [StarveW-1:0]  starve_q, starve_d;
  logic                rw_q, rw_d;
  logic [RegAddrW-1:0] da_q, da_d;
  logic [DataW-1:0]    busd_q, busd_d;

  // m_ready depends only on stored occupancy (and reset), never on same-cycle requests.
  assign m_ready    = !rst && !fifo_full;
  assign push       = m_valid && m_ready;

  assign p_stall    = !rst && head_present && (starve_q == StarveW'(STARVE_MAX));
  assign grant_p    = !rst && p_RW && !p_stall;
  // A cancelled head is discarded even while the pipeline owns the port.
  assign pop_head   = !rst && head_present && (!grant_p || !head_valid);
  assign write_head = pop_head && head_valid;

  wb_result_fifo #(
    .Depth(WbFifoDepth)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (push),
    .push_da_i     (m_DA),
    .push_data_i   (m_data),
    .pop_i         (pop_head),
    .cancel_i      (grant_p),
    .cancel_da_i   (p_DA),
    .full_o        (fifo_full),
    .head_present_o(head_present),
    .head_valid_o  (head_valid),
    .head_da_o     (head_da),
    .head_data_o   (head_data)
  );

  // Starve counter tracks how long the current head has been passed over.
  always_comb begin
    starve_d = starve_q;
    if (!head_present || pop_head) begin
      starve_d = '0;
    end else if (grant_p) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // Write-port selection; address and data hold their last value when idle.
  always_comb begin
    rw_d   = grant_p || write_head;
    da_d   = da_q;
    busd_d = busd_q;
    if (grant_p) begin
      da_d   = p_DA;
      busd_d = p_data;
    end else if (write_head) begin
      da_d   = head_da;
      busd_d = head_data;
    end
  end

  // Registered write port and starve counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rw_q     <= 1'b0;
      da_q     <= '0;
      busd_q   <= '0;
    end else begin
      starve_q <= starve_d;
      rw_q     <= rw_d;
      da_q     <= da_d;
      busd_q   <= busd_d;
    end
  end

  assign RW   = rw_q;
  assign DA   = da_q;
  assign BusD = busd_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench: stimulus pushes expected writes into a scoreboard, a negedge monitor checks them.
module tb_wb_port_scheduler;

  logic        clk;
  logic        rst;
  logic        p_RW;
  logic [4:0]  p_DA;
  logic [31:0] p_data;
  logic        p_stall;
  logic        m_valid;
  logic [4:0]  m_DA;
  logic [31:0] m_data;
  logic        m_ready;
  logic        RW;
  logic [4:0]  DA;
  logic [31:0] BusD;

  typedef struct {
    logic [4:0]  da;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   idx;

  wb_port_scheduler #(
    .STARVE_MAX(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .p_RW   (p_RW),
    .p_DA   (p_DA),
    .p_data (p_data),
    .p_stall(p_stall),
    .m_valid(m_valid),
    .m_DA   (m_DA),
    .m_data (m_data),
    .m_ready(m_ready),
    .RW     (RW),
    .DA     (DA),
    .BusD   (BusD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every RW pulse must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    if (RW === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL sb_write: unexpected write cyc=%0d DA=%0d BusD=%h, required no write",
                 cyc, DA, BusD);
      end else begin
        mon_e = exp_q.pop_front();
        if (DA !== mon_e.da || BusD !== mon_e.data || cyc != mon_e.cyc) begin
          n_errs++;
          $display("FAIL sb_write: got cyc=%0d DA=%0d BusD=%h, required cyc=%0d DA=%0d BusD=%h",
                   cyc, DA, BusD, mon_e.cyc, mon_e.da, mon_e.data);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      n_checks++;
      n_errs++;
      mon_e = exp_q.pop_front();
      $display("FAIL sb_missing: got no write at cyc=%0d, required DA=%0d BusD=%h at cyc=%0d",
               cyc, mon_e.da, mon_e.data, mon_e.cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errs++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_RW    = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    // Reset with busy inputs: they must be ignored.
    rst = 1'b1; p_RW = 1'b1; p_DA = 5'd1; p_data = 32'hFFFF; m_valid = 1'b1; m_DA = 5'd2;
    m_data = 32'h1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_p_stall", {31'd0, p_stall}, 32'd0);
    check("rst_m_ready", {31'd0, m_ready}, 32'd0);
    check("rst_RW", {31'd0, RW}, 32'd0);
    check("rst_DA", {27'd0, DA}, 32'd0);
    check("rst_BusD", BusD, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("post_rst_m_ready", {31'd0, m_ready}, 32'd1);
    check("post_rst_RW", {31'd0, RW}, 32'd0);
    tick();

    // Plain pipeline write, visible exactly one cycle.
    p_RW = 1'b1; p_DA = 5'd5; p_data = 32'hDEADBEEF;
    exp_q.push_back('{5'd5, 32'hDEADBEEF, cyc + 1});
    tick();
    p_RW = 1'b0;
    @(negedge clk);
    check("pipe_RW", {31'd0, RW}, 32'd1);
    tick();
    @(negedge clk);
    check("pipe_one_cycle", {31'd0, RW}, 32'd0);
    check("idle_DA_hold", {27'd0, DA}, 32'd5);
    check("idle_BusD_hold", BusD, 32'hDEADBEEF);
    tick();

    // Multi-cycle result with idle pipeline: two-cycle latency.
    m_valid = 1'b1; m_DA = 5'd9; m_data = 32'h1234;
    exp_q.push_back('{5'd9, 32'h1234, cyc + 2});
    tick();
    m_valid = 1'b0;
    @(negedge clk);
    check("m_latency_early", {31'd0, RW}, 32'd0);
    tick();
    @(negedge clk);
    check("m_latency", {31'd0, RW}, 32'd1);
    tick();

    // DA=0 is an ordinary register.
    p_RW = 1'b1; p_DA = 5'd0; p_data = 32'hA5A5A5A5;
    exp_q.push_back('{5'd0, 32'hA5A5A5A5, cyc + 1});
    tick();
    idle();
    repeat (2) tick();

    // Starvation: two queued results against a continuous pipeline stream (DA 7).
    m_valid = 1'b1; m_DA = 5'd3; m_data = 32'h333;
    tick();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      m_valid = (k == 0); m_DA = 5'd4; m_data = 32'h444;
      p_RW = 1'b1; p_DA = 5'd7; p_data = 32'h7000 + 32'(idx);
      @(negedge clk);
      check("starve_p_stall", {31'd0, p_stall}, {31'd0, (k == 4 || k == 9)});
      check("starve_m_ready", {31'd0, m_ready}, {31'd0, !(k >= 1 && k <= 4)});
      if (k == 4) begin
        exp_q.push_back('{5'd3, 32'h333, cyc + 1});
      end else if (k == 9) begin
        exp_q.push_back('{5'd4, 32'h444, cyc + 1});
      end else begin
        exp_q.push_back('{5'd7, 32'h7000 + 32'(idx), cyc + 1});
        idx++;
      end
      tick();
    end
    idle();
    repeat (3) tick();

    // Cancellation: pipeline writes DA 6 while an older result for DA 6 is queued.
    m_valid = 1'b1; m_DA = 5'd6; m_data = 32'h66;
    tick();
    m_valid = 1'b0;
    p_RW = 1'b1; p_DA = 5'd6; p_data = 32'h600D;
    exp_q.push_back('{5'd6, 32'h600D, cyc + 1});
    @(negedge clk);
    check("cancel_no_stall", {31'd0, p_stall}, 32'd0);
    tick();
    // Stale head is discarded while the pipeline keeps the port.
    p_DA = 5'd8; p_data = 32'h88;
    exp_q.push_back('{5'd8, 32'h88, cyc + 1});
    tick();
    p_RW = 1'b0;
    tick();
    @(negedge clk);
    check("cancel_no_stale", {31'd0, RW}, 32'd0);
    repeat (3) tick();

    // Reset while full: queued results never reach the register file.
    m_valid = 1'b1; m_DA = 5'd10; m_data = 32'hAA;
    tick();
    m_DA = 5'd11; m_data = 32'hBB; p_RW = 1'b1; p_DA = 5'd12; p_data = 32'hCC;
    exp_q.push_back('{5'd12, 32'hCC, cyc + 1});
    tick();
    idle();
    @(negedge clk);
    check("full_m_ready", {31'd0, m_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_m_ready", {31'd0, m_ready}, 32'd0);
    check("midrst_p_stall", {31'd0, p_stall}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_RW", {31'd0, RW}, 32'd0);
    check("after_rst_m_ready", {31'd0, m_ready}, 32'd1);
    repeat (8) tick();

    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
